// File: rtl/encap_result_reader.sv
// encap_result_reader
//   Drains the three encapsulation result memories after encap_seq_gen
//   finishes: C0 (syndrome ciphertext), then C1 (hash confirmation), then
//   K (session key). It emits them as one tagged 32-bit word stream with
//   valid/ready handshaking for the UART/host link.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start             one-cycle pulse from encap done; ignored unless idle
//   rd_C0/C0_addr     C0 read strobe/address; C0_out arrives one cycle later
//   rd_C1/C1_addr     C1 read strobe/address; C1_out arrives one cycle later
//   rd_K/K_addr       K read strobe/address;  K_out arrives one cycle later
//   dout/dout_sel     stream word and source tag (0=C0, 1=C1, 2=K)
//   dout_last         marks the final K word
//   dout_valid/ready  stream handshake
//   busy              high from start acceptance until done
//   done              one-cycle pulse after the final word transfers

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module encap_result_reader #(
  parameter int m        = 12,
  parameter int t        = 64,
  parameter int C0_WORDS = (m * t + 31) / 32,
  parameter int C1_WORDS = 8,
  parameter int K_WORDS  = 8,
  parameter int C0_AW    = `CLOG2(C0_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             rd_C0,
  output logic [C0_AW-1:0] C0_addr,
  input  logic [31:0]      C0_out,
  output logic             rd_C1,
  output logic [2:0]       C1_addr,
  input  logic [31:0]      C1_out,
  output logic             rd_K,
  output logic [2:0]       K_addr,
  input  logic [31:0]      K_out,
  output logic [31:0]      dout,
  output logic [1:0]       dout_sel,
  output logic             dout_last,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             done
);

  // Shared word counter, wide enough for the largest region.
  localparam int AW = (C0_AW > 3) ? C0_AW : 3;

  typedef enum logic [2:0] {IDLE, RD_C0, RD_C1, RD_K, DRAIN, FIN} state_t;

  state_t        state_q;
  logic [AW-1:0] addr_q;
  logic          busy_q;
  logic          done_q;

  // Read issued last cycle: its data is on the *_out bus this cycle.
  logic          pend_q;
  logic [1:0]    pend_sel_q;
  logic          pend_last_q;

  // 2-entry output FIFO.
  logic [31:0]   fifo_data_q [2];
  logic [1:0]    fifo_sel_q  [2];
  logic          fifo_last_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    occ_q;

  logic          pop;
  logic          push;
  logic          issue;
  logic          region_end;
  logic [AW-1:0] last_addr;
  logic [1:0]    cur_sel;
  logic [31:0]   cap_data;
  logic [2:0]    committed;

  always_comb begin
    pop  = (occ_q != 2'd0) && dout_ready;
    push = pend_q;

    // Words already owned by the FIFO or on the bus after this cycle's pop.
    // Keeping this below 2 before issuing guarantees the FIFO never overflows,
    // and still allows one read per cycle when the consumer keeps up.
    committed = 3'(occ_q) + 3'(pend_q) - 3'(pop);
    issue     = (state_q inside {RD_C0, RD_C1, RD_K}) && (committed < 3'd2);

    last_addr = '0;
    cur_sel   = 2'd0;
    case (state_q)
      RD_C0:   begin last_addr = AW'(C0_WORDS - 1); cur_sel = 2'd0; end
      RD_C1:   begin last_addr = AW'(C1_WORDS - 1); cur_sel = 2'd1; end
      RD_K:    begin last_addr = AW'(K_WORDS - 1);  cur_sel = 2'd2; end
      default: begin last_addr = '0;                cur_sel = 2'd0; end
    endcase
    region_end = issue && (addr_q == last_addr);

    case (pend_sel_q)
      2'd0:    cap_data = C0_out;
      2'd1:    cap_data = C1_out;
      default: cap_data = K_out;
    endcase
  end

  assign rd_C0   = issue && (state_q == RD_C0);
  assign rd_C1   = issue && (state_q == RD_C1);
  assign rd_K    = issue && (state_q == RD_K);
  assign C0_addr = (state_q == RD_C0) ? addr_q[C0_AW-1:0] : '0;
  assign C1_addr = (state_q == RD_C1) ? addr_q[2:0] : '0;
  assign K_addr  = (state_q == RD_K)  ? addr_q[2:0] : '0;

  assign dout       = fifo_data_q[rd_ptr_q];
  assign dout_sel   = fifo_sel_q[rd_ptr_q];
  assign dout_last  = fifo_last_q[rd_ptr_q];
  assign dout_valid = (occ_q != 2'd0);
  assign busy       = busy_q;
  assign done       = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_sel_q  <= 2'd0;
      pend_last_q <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_sel_q[i]  <= 2'd0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      // Tag and last flag travel with the read so the capture needs no state.
      pend_q <= issue;
      if (issue) begin
        pend_sel_q  <= cur_sel;
        pend_last_q <= (state_q == RD_K) && region_end;
      end

      if (push) begin
        fifo_data_q[wr_ptr_q] <= cap_data;
        fifo_sel_q[wr_ptr_q]  <= pend_sel_q;
        fifo_last_q[wr_ptr_q] <= pend_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};

      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RD_C0;
            addr_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        RD_C0, RD_C1, RD_K: begin
          if (issue) begin
            if (region_end) begin
              addr_q <= '0;
              case (state_q)
                RD_C0:   state_q <= RD_C1;
                RD_C1:   state_q <= RD_K;
                default: state_q <= DRAIN;
              endcase
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if ((occ_q == 2'd0) && !pend_q) begin
            state_q <= FIN;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        FIN: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && (occ_q == 2'd2)));

endmodule

// File: tb/tb_encap_result_reader.sv
module tb_encap_result_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        dout_ready = 1'b0;
  logic        rd_C0, rd_C1, rd_K;
  logic [4:0]  C0_addr;
  logic [2:0]  C1_addr, K_addr;
  logic [31:0] C0_out = '0, C1_out = '0, K_out = '0;
  logic [31:0] dout;
  logic [1:0]  dout_sel;
  logic        dout_last, dout_valid, busy, done;

  typedef struct packed {
    logic [1:0]  sel;
    logic        last;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   issued = 0;
  int   popped = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  int   first_pop_cyc = 0;
  int   last_pop_cyc = 0;
  int   ready_mode = 0;   // 0: dout_ready driven by stimulus, 1: random
  logic        stalled = 1'b0;
  logic [31:0] hold_data = '0;
  logic [1:0]  hold_sel = '0;
  logic        hold_last = 1'b0;

  encap_result_reader dut (
    .clk(clk), .rst(rst), .start(start),
    .rd_C0(rd_C0), .C0_addr(C0_addr), .C0_out(C0_out),
    .rd_C1(rd_C1), .C1_addr(C1_addr), .C1_out(C1_out),
    .rd_K(rd_K), .K_addr(K_addr), .K_out(K_out),
    .dout(dout), .dout_sel(dout_sel), .dout_last(dout_last),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Result memories: one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_C0) C0_out <= 32'hC000_0000 + 32'(C0_addr);
    if (rd_C1) C1_out <= 32'hC100_0000 + 32'(C1_addr);
    if (rd_K)  K_out  <= 32'h4B00_0000 + 32'(K_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard: samples on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    int   n_rd;
    if (!rst) begin
      stalled = 1'b0;
    end else begin
      n_rd = int'(rd_C0) + int'(rd_C1) + int'(rd_K);
      check("strobe_onehot", 32'(n_rd <= 1), 1);
      check("addr_range", 32'(C0_addr <= 5'd23 && C1_addr <= 3'd7 && K_addr <= 3'd7), 1);
      if (n_rd != 0) issued++;
      if (stalled && dout_valid) begin
        check("stall_data", dout, hold_data);
        check("stall_sel", 32'(dout_sel), 32'(hold_sel));
        check("stall_last", 32'(dout_last), 32'(hold_last));
      end
      if (dout_valid && dout_ready) begin
        popped++;
        if (popped == 1) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        $display("[TB] word %0d sel=%0d data=0x%08h last=%0d", popped - 1, dout_sel, dout, dout_last);
        if (sb.size() == 0) begin
          check("unexpected_word", dout, 32'hxxxx_xxxx);
        end else begin
          e = sb.pop_front();
          check("word_data", dout, e.data);
          check("word_sel", 32'(dout_sel), 32'(e.sel));
          check("word_last", 32'(dout_last), 32'(e.last));
        end
      end
      check("outstanding", 32'((issued - popped) <= 2), 1);
      stalled   = dout_valid && !dout_ready;
      hold_data = dout;
      hold_sel  = dout_sel;
      hold_last = dout_last;
      if (done) done_cnt++;
    end
  end

  // Random backpressure driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) dout_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic begin_run();
    sb.delete();
    issued = 0;
    popped = 0;
    done_cnt = 0;
    first_pop_cyc = 0;
    last_pop_cyc = 0;
    for (int i = 0; i < 24; i++) sb.push_back({2'd0, 1'b0, 32'hC000_0000 + 32'(i)});
    for (int i = 0; i < 8; i++)  sb.push_back({2'd1, 1'b0, 32'hC100_0000 + 32'(i)});
    for (int i = 0; i < 8; i++)  sb.push_back({2'd2, (i == 7), 32'h4B00_0000 + 32'(i)});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic finish_run(input string name);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, 32'(done_cnt != 0), 1);
    repeat (5) @(negedge clk);
    check({name, "_done_once"}, 32'(done_cnt), 1);
    check({name, "_busy_low"}, 32'(busy), 0);
    check({name, "_words"}, 32'(popped), 40);
    check({name, "_sb_empty"}, 32'(sb.size()), 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_rd"}, {29'd0, rd_C0, rd_C1, rd_K}, 0);
    check({name, "_addr"}, {21'd0, C0_addr, C1_addr, K_addr}, 0);
    check({name, "_dout"}, dout, 0);
    check({name, "_sel_last"}, {29'd0, dout_sel, dout_last}, 0);
    check({name, "_valid"}, 32'(dout_valid), 0);
    check({name, "_busy_done"}, {30'd0, busy, done}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int n;

    // Reset state.
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("idle");

    // 1: full-rate drain, latency and no bubbles.
    begin_run();
    dout_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;   // start sampled at this edge (E0)
    edges = 1;
    check("lat_rd_C0", {31'd0, rd_C0}, 1);
    check("lat_addr0", 32'(C0_addr), 0);
    check("lat_busy", 32'(busy), 1);
    while (!dout_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check("latency_edges", 32'(edges), 3);
    finish_run("full");
    check("full_no_bubble", 32'(last_pop_cyc - first_pop_cyc), 39);

    // 2: random 50% backpressure.
    begin_run();
    ready_mode = 1;
    pulse_start();
    finish_run("rand");
    ready_mode = 0;

    // 3: consumer stalled for 20 cycles after the first valid word.
    begin_run();
    dout_ready = 1'b0;
    pulse_start();
    n = 0;
    while (!dout_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_valid_seen", 32'(dout_valid), 1);
    repeat (20) @(negedge clk);
    check("stall_reads", 32'(issued), 2);
    check("stall_no_strobe", {29'd0, rd_C0, rd_C1, rd_K}, 0);
    @(posedge clk); #1 dout_ready = 1'b1;
    @(negedge clk);
    check("resume_rd", 32'(rd_C0), 1);
    check("resume_addr", 32'(C0_addr), 2);
    finish_run("stall");

    // 4: second start mid-drain is ignored.
    begin_run();
    dout_ready = 1'b1;
    pulse_start();
    n = 0;
    while (popped < 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("restart_at10", 32'(popped >= 10), 1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    finish_run("restart");

    // 5: reset in the middle of the drain, then a fresh drain.
    begin_run();
    pulse_start();
    n = 0;
    while (popped < 30 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_at30", 32'(popped >= 30), 1);
    @(posedge clk); #1 rst = 1'b0;
    #1 check_all_zero("midrst");
    sb.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    begin_run();
    pulse_start();
    finish_run("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
